// File: rtl/uart_lite_axi_tx_pkg.sv
// Shared types and default register map for the UART-Lite AXI4-Lite TX master.
package uart_lite_axi_pkg;

  typedef enum logic [2:0] {
    CTRL       = 3'd0,
    CTRL_RESP  = 3'd1,
    IDLE       = 3'd2,
    POLL_AR    = 3'd3,
    POLL_R     = 3'd4,
    WRITE      = 3'd5,
    WRITE_RESP = 3'd6
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned DEF_CTRL_ADDR  = 'hC;
  localparam int unsigned DEF_TX_ADDR    = 'h4;
  localparam int unsigned DEF_STAT_ADDR  = 'h8;
  localparam logic [7:0]  DEF_CTRL_WORD  = 8'h03;
  localparam int unsigned DEF_TXFULL_BIT = 3;

endpackage

// File: rtl/uart_lite_axi_tx_if.sv
// AXI4-Lite write/read channels between the TX master and the UART-Lite slave.
interface uart_lite_axi_tx_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [7:0]        wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [7:0]        rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/uart_lite_axi_tx_fifo.sv
// Synchronous byte FIFO with registered occupancy; DEPTH must be a power of two.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/uart_lite_axi_tx.sv
// AXI4-Lite master draining a byte FIFO into a UART-Lite TX register.
// Optional TX-full status polling before each write: define UART_TX_STAT_POLL_EN.
module uart_lite_axi_tx
  import uart_lite_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned CTRL_ADDR  = DEF_CTRL_ADDR,
  parameter int unsigned TX_ADDR    = DEF_TX_ADDR,
  parameter int unsigned STAT_ADDR  = DEF_STAT_ADDR,
  parameter logic [7:0]  CTRL_WORD  = DEF_CTRL_WORD,
  parameter int unsigned TXFULL_BIT = DEF_TXFULL_BIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          err,
  uart_lite_axi_tx_if.master            bus
);
  localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

  state_e     state_q, state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [3:0] retry_q, retry_d;
  logic       err_q, err_d;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       aw_hs, w_hs;

  assign s_ready = !fifo_full;
  assign err     = err_q;

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .din   (s_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  // Bus outputs depend only on registered state, never on an incoming ready.
  always_comb begin
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    case (state_q)
      CTRL: begin
        bus.awaddr  = ADDR_W'(CTRL_ADDR);
        bus.awvalid = !aw_done_q;
        bus.wdata   = CTRL_WORD;
        bus.wvalid  = !w_done_q;
      end
      WRITE: begin
        bus.awaddr  = ADDR_W'(TX_ADDR);
        bus.awvalid = !aw_done_q;
        bus.wdata   = fifo_head;
        bus.wvalid  = !w_done_q;
      end
      CTRL_RESP, WRITE_RESP: bus.bready = 1'b1;
`ifdef UART_TX_STAT_POLL_EN
      POLL_AR: begin
        bus.araddr  = ADDR_W'(STAT_ADDR);
        bus.arvalid = 1'b1;
      end
      POLL_R: bus.rready = 1'b1;
`endif
      default: ;
    endcase
  end

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    retry_d   = retry_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    case (state_q)
      CTRL, WRITE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = (state_q == CTRL) ? CTRL_RESP : WRITE_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      CTRL_RESP, WRITE_RESP: begin
        if (bus.bvalid) begin
          if (bus.bresp == AXI_RESP_OKAY) begin
            fifo_pop = (state_q == WRITE_RESP);
            state_d  = IDLE;
            retry_d  = '0;
          end else if (retry_q < MaxRetry) begin
            retry_d = retry_q + 4'd1;
            state_d = (state_q == CTRL_RESP) ? CTRL : WRITE;
          end else begin
            // Retries exhausted: drop the byte and flag it.
            err_d    = 1'b1;
            fifo_pop = (state_q == WRITE_RESP);
            state_d  = IDLE;
            retry_d  = '0;
          end
        end
      end
      IDLE: begin
        if (!fifo_empty) begin
`ifdef UART_TX_STAT_POLL_EN
          state_d = POLL_AR;
`else
          state_d = WRITE;
`endif
        end
      end
`ifdef UART_TX_STAT_POLL_EN
      POLL_AR: begin
        if (bus.arready) state_d = POLL_R;
      end
      POLL_R: begin
        if (bus.rvalid) begin
          if (bus.rresp == AXI_RESP_OKAY && !bus.rdata[TXFULL_BIT]) state_d = WRITE;
          else                                                       state_d = POLL_AR;
        end
      end
`endif
      default: state_d = CTRL;
    endcase
  end

`ifndef UART_TX_STAT_POLL_EN
  logic unused_rd;
  assign unused_rd = ^{bus.arready, bus.rvalid, bus.rresp, bus.rdata,
                       ADDR_W'(STAT_ADDR), 8'(TXFULL_BIT)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CTRL;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      retry_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_lite_axi_tx.sv
// Self-checking bench for uart_lite_axi_tx: directed table plus handshake corner cases.
module tb_uart_lite_axi_tx;
  import uart_lite_axi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] level;
  logic       err;

  uart_lite_axi_tx_if #(.ADDR_W(4)) bus ();

  uart_lite_axi_tx #(
    .MAX_RETRY (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .level   (level),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Slave model: logs handshakes, answers each bready with one bvalid.
  int         b_count     = 0;
  int         fail_given  = 0;
  int         fail_target = 0;
  logic [3:0] aw_log[$];
  logic [7:0] w_log[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.awvalid && bus.awready) aw_log.push_back(bus.awaddr);
      if (bus.wvalid && bus.wready)   w_log.push_back(bus.wdata);
      if (bus.bvalid && bus.bready) begin
        b_count++;
        if (bus.bresp != AXI_RESP_OKAY) fail_given++;
      end
    end
  end

  always @(negedge clk) begin
    bus.bvalid = bus.bready;
    bus.bresp  = (fail_given < fail_target) ? 2'b10 : 2'b00;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_b(input int target, input int budget);
    int i = 0;
    while (b_count < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    check("bresp_wait", int'(b_count >= target), 1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         fails;
    int         exp_writes;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int sa, sw, sb;
    // MAX_RETRY=2: up to 3 writes per byte; 3 failures drops it and sets err.
    vecs[0] = '{data: 8'h41, fails: 0, exp_writes: 1, exp_err: 0};
    vecs[1] = '{data: 8'h42, fails: 1, exp_writes: 2, exp_err: 0};
    vecs[2] = '{data: 8'h43, fails: 2, exp_writes: 3, exp_err: 0};
    vecs[3] = '{data: 8'h55, fails: 3, exp_writes: 3, exp_err: 1};
    vecs[4] = '{data: 8'h66, fails: 0, exp_writes: 1, exp_err: 1};

    s_valid     = 1'b0;
    s_data      = 8'h00;
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    bus.arready = 1'b0;
    bus.rdata   = 8'h00;
    bus.rresp   = 2'b00;
    bus.rvalid  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_level", level, 0);
    check("rst_err", err, 0);
    check("rst_awaddr", bus.awaddr, 'hC);
    check("rst_awvalid", bus.awvalid, 1);
    check("rst_wdata", bus.wdata, 'h03);
    check("rst_wvalid", bus.wvalid, 1);
    check("rst_bready", bus.bready, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_araddr", bus.araddr, 0);
    check("rst_rready", bus.rready, 0);
    rst = 1'b0;

    // Control register write after reset.
    wait_b(1, 20);
    repeat (2) @(negedge clk);
    check("ctrl_n_aw", aw_log.size(), 1);
    check("ctrl_n_w", w_log.size(), 1);
    check("ctrl_addr", aw_log[0], 'hC);
    check("ctrl_data", w_log[0], 'h03);
    check("idle_awvalid", bus.awvalid, 0);
    check("idle_wvalid", bus.wvalid, 0);
    check("idle_bready", bus.bready, 0);

    // Table: one byte per record with a scripted number of SLVERR responses.
    for (int i = 0; i < 5; i++) begin
      sa = aw_log.size();
      sw = w_log.size();
      sb = b_count;
      fail_target = fail_given + vecs[i].fails;
      push_byte(vecs[i].data);
      wait_b(sb + vecs[i].exp_writes, 100);
      repeat (6) @(negedge clk);
      check($sformatf("v%0d_n_w", i), w_log.size() - sw, vecs[i].exp_writes);
      check($sformatf("v%0d_n_aw", i), aw_log.size() - sa, vecs[i].exp_writes);
      for (int j = sw; j < w_log.size(); j++)
        check($sformatf("v%0d_wdata", i), w_log[j], vecs[i].data);
      for (int j = sa; j < aw_log.size(); j++)
        check($sformatf("v%0d_awaddr", i), aw_log[j], 'h4);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_level", i), level, 0);
    end

    // Three back-to-back pushes with a zero-wait slave.
    sw = w_log.size();
    sb = b_count;
    @(negedge clk); s_valid = 1'b1; s_data = 8'h41;
    @(negedge clk); s_data = 8'h42;
    @(negedge clk); s_data = 8'h43;
    @(negedge clk); s_valid = 1'b0;
    check("b2b_level_peak", level, 3);
    @(negedge clk); @(negedge clk);
    check("b2b_level_step", level, 2);
    wait_b(sb + 3, 100);
    repeat (4) @(negedge clk);
    check("b2b_n_w", w_log.size() - sw, 3);
    check("b2b_w0", w_log[sw], 'h41);
    check("b2b_w1", w_log[sw+1], 'h42);
    check("b2b_w2", w_log[sw+2], 'h43);
    check("b2b_level_end", level, 0);

    // awready ahead of wready: address handshake completes first.
    sa = aw_log.size();
    sw = w_log.size();
    sb = b_count;
    bus.wready = 1'b0;
    push_byte(8'h5A);
    for (int i = 0; i < 20 && !bus.awvalid; i++) @(negedge clk);
    check("split_awvalid_seen", bus.awvalid, 1);
    @(negedge clk);
    check("split_aw_dropped", bus.awvalid, 0);
    check("split_w_held", bus.wvalid, 1);
    repeat (2) @(negedge clk);
    check("split_w_held2", bus.wvalid, 1);
    check("split_no_bready", bus.bready, 0);
    bus.wready = 1'b1;
    wait_b(sb + 1, 20);
    repeat (4) @(negedge clk);
    check("split_n_b", b_count - sb, 1);
    check("split_n_aw", aw_log.size() - sa, 1);
    check("split_n_w", w_log.size() - sw, 1);
    check("split_wdata", w_log[sw], 'h5A);

    // Fill the FIFO while the address channel is stalled.
    sw = w_log.size();
    sb = b_count;
    bus.awready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h80 + 8'(i);
    end
    @(negedge clk);
    check("full_s_ready", s_ready, 0);
    check("full_level", level, 16);
    s_data = 8'hFF;
    @(negedge clk);
    s_valid = 1'b0;
    check("full_level_hold", level, 16);
    bus.awready = 1'b1;
    wait_b(sb + 16, 400);
    repeat (6) @(negedge clk);
    check("full_n_w", w_log.size() - sw, 16);
    for (int i = 0; i < 16; i++) check("full_order", w_log[sw+i], 'h80 + i);
    check("full_drained", level, 0);
    check("full_s_ready_end", s_ready, 1);

    // Reset in the middle of a write flushes the FIFO and clears err.
    bus.awready = 1'b0;
    push_byte(8'h77);
    push_byte(8'h78);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_level", level, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_awaddr", bus.awaddr, 'hC);
    check("mid_rst_wdata", bus.wdata, 'h03);
    bus.awready = 1'b1;
    sa = aw_log.size();
    sw = w_log.size();
    sb = b_count;
    rst = 1'b0;
    wait_b(sb + 1, 20);
    repeat (6) @(negedge clk);
    check("mid_rst_n_w", w_log.size() - sw, 1);
    check("mid_rst_ctrl_addr", aw_log[sa], 'hC);
    check("mid_rst_ctrl_data", w_log[sw], 'h03);
    check("mid_rst_idle", bus.awvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
